mem_arbiter: RTL

Two-port memory bus arbiter that shares the single memory interface (address/data/we/start → q/busy) between the B322 CPU and a DMA requester. Each requester sees an interface identical to a private memory port; the arbiter latches one-cycle start pulses, arbitrates round-robin, and forwards one transaction at a time. It sits between the CPU top-level memory pins and the memory unit.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_req_latch.sv | 38 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the CPU/DMA memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACTIVE,
    DONE
  } arb_state_t;

  // A lone requester wins outright; a tie goes to the port that was not served last.
  function automatic logic pick_owner(input logic cpu_pend, input logic dma_pend,
                                      input logic last_grant);
    if (cpu_pend && dma_pend) begin
      return ~last_grant;
    end else if (cpu_pend) begin
      return PORT_CPU;
    end else begin
      return PORT_DMA;
    end
  endfunction

endpackage

// File: rtl/mem_req_latch.sv
// rtl/mem_req_latch.sv - per-port request latch holding one outstanding memory request
module mem_req_latch
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  output logic [ADDR_W-1:0] lat_address,
  output logic [DATA_W-1:0] lat_data,
  output logic              lat_we,
  output logic              pending
);

  // A start while a request is already held is dropped, so the held fields never move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_address <= '0;
      lat_data    <= '0;
      lat_we      <= 1'b0;
      pending     <= 1'b0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (start && !pending) begin
      lat_address <= address;
      lat_data    <= data;
      lat_we      <= we;
      pending     <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between CPU and DMA
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_we,
  input  logic              cpu_start,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_busy,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              dma_we,
  input  logic              dma_start,
  output logic [DATA_W-1:0] dma_q,
  output logic              dma_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_busy
);

  logic [ADDR_W-1:0] cpu_lat_address, dma_lat_address, sel_address;
  logic [DATA_W-1:0] cpu_lat_data, dma_lat_data, sel_data;
  logic              cpu_lat_we, dma_lat_we, sel_we;
  logic              cpu_pending, dma_pending;
  logic              cpu_clear, dma_clear;
  logic              next_owner;

  arb_state_t state;
  logic       owner;
  logic       last_grant;
  logic       seen_busy;

  assign cpu_clear = (state == DONE) && (owner == PORT_CPU);
  assign dma_clear = (state == DONE) && (owner == PORT_DMA);

  mem_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu_latch (
    .clk        (clk),
    .reset      (reset),
    .start      (cpu_start),
    .clear      (cpu_clear),
    .address    (cpu_address),
    .data       (cpu_data),
    .we         (cpu_we),
    .lat_address(cpu_lat_address),
    .lat_data   (cpu_lat_data),
    .lat_we     (cpu_lat_we),
    .pending    (cpu_pending)
  );

  mem_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dma_latch (
    .clk        (clk),
    .reset      (reset),
    .start      (dma_start),
    .clear      (dma_clear),
    .address    (dma_address),
    .data       (dma_data),
    .we         (dma_we),
    .lat_address(dma_lat_address),
    .lat_data   (dma_lat_data),
    .lat_we     (dma_lat_we),
    .pending    (dma_pending)
  );

  // A queued request keeps its port busy for the whole wait behind the other port.
  assign cpu_busy = cpu_pending;
  assign dma_busy = dma_pending;

  always_comb begin
    next_owner  = pick_owner(cpu_pending, dma_pending, last_grant);
    sel_address = dma_lat_address;
    sel_data    = dma_lat_data;
    sel_we      = dma_lat_we;
    if (next_owner == PORT_CPU) begin
      sel_address = cpu_lat_address;
      sel_data    = cpu_lat_data;
      sel_we      = cpu_lat_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= PORT_CPU;
      last_grant  <= PORT_DMA;
      seen_busy   <= 1'b0;
      mem_start   <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      cpu_q       <= '0;
      dma_q       <= '0;
    end else begin
      mem_start <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_pending || dma_pending) begin
            owner       <= next_owner;
            mem_address <= sel_address;
            mem_data    <= sel_data;
            mem_we      <= sel_we;
            mem_start   <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          seen_busy <= 1'b0;
          state     <= ACTIVE;
        end
        // Completion needs a busy-high cycle first, so a late-rising busy is not mistaken for done.
        ACTIVE: begin
          if (mem_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!mem_we) begin
            if (owner == PORT_CPU) begin
              cpu_q <= mem_q;
            end else begin
              dma_q <= mem_q;
            end
          end
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
